// File: rtl/life_pkg.sv
// Shared types for the life datapath frame loader.
package life_pkg;

   // Frame loader control states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } loader_state_t;

endpackage

// File: rtl/demux_load_n_decoder.sv
// Binary-to-one-hot decoder: the write-side counterpart of the mux_n read tree.
// Only the N real cell positions are produced; codes >= N light no output.
module decoder_n #(
   parameter int N = 8
) (
   input  logic [$clog2(N)-1:0] a,
   input  logic                 en,
   output logic [N-1:0]         y
);

   localparam int AW = $clog2(N);

   // One-hot select of cell a, gated by en.
   always_comb begin
      y = '0;
      for (int i = 0; i < N; i++) begin
         if (en && (a == AW'(i))) begin
            y[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/demux_load_n.sv
// Serial-to-parallel frame loader. Cell bits arrive one per accepted
// handshake, are steered into a shadow register by the write address, and
// the complete frame is committed to q in a single edge so downstream logic
// never observes a partially loaded frame.
module demux_load_n
   import life_pkg::*;
#(
   parameter int N = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load_start,
   input  logic                 abort,
   input  logic                 din,
   input  logic                 din_valid,
   output logic                 din_ready,
   output logic [$clog2(N)-1:0] addr,
   output logic [N-1:0]         q,
   output logic                 busy,
   output logic                 frame_done
);

   localparam int            AW   = $clog2(N);
   localparam logic [AW-1:0] LAST = AW'(N - 1);

   loader_state_t r_state;
   loader_state_t w_next_state;
   logic [AW-1:0] r_addr;
   logic [N-1:0]  r_shadow;
   logic [N-1:0]  r_q;

   logic          w_accept;
   logic          w_last;
   logic          w_start;
   logic [N-1:0]  w_we;
   logic [N-1:0]  w_shadow_nxt;

   // Abort has priority: a bit presented alongside abort is dropped.
   assign w_accept = (r_state == LOAD) && din_valid && !abort;
   assign w_last   = (r_addr == LAST);
   assign w_start  = (r_state == IDLE) && load_start;

   decoder_n #(.N(N)) u_dec (
      .a  (r_addr),
      .en (w_accept),
      .y  (w_we)
   );

   // Shadow with the current bit merged in; on the last accept this is the
   // full frame, so it feeds the commit directly and saves a cycle.
   assign w_shadow_nxt = (r_shadow & ~w_we) | ({N{din}} & w_we);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic; status outputs depend on the current state only.
   always_comb begin
      w_next_state = r_state;
      din_ready    = 1'b0;
      busy         = 1'b0;
      frame_done   = 1'b0;
      case (r_state)
         IDLE: begin
            if (load_start) begin
               w_next_state = LOAD;
            end
         end
         LOAD: begin
            din_ready = 1'b1;
            busy      = 1'b1;
            if (abort) begin
               w_next_state = IDLE;
            end else if (w_accept && w_last) begin
               w_next_state = DONE;
            end
         end
         DONE: begin
            busy         = 1'b1;
            frame_done   = 1'b1;
            w_next_state = IDLE;
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // Write address and shadow frame; address wraps to 0 after cell N-1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr   <= '0;
         r_shadow <= '0;
      end else if (w_start) begin
         r_addr   <= '0;
         r_shadow <= '0;
      end else if (r_state == LOAD) begin
         if (abort) begin
            r_addr   <= '0;
            r_shadow <= '0;
         end else if (w_accept) begin
            r_shadow <= w_shadow_nxt;
            r_addr   <= w_last ? '0 : r_addr + 1'b1;
         end
      end
   end

   // Committed frame; changes only on the final accept of a frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q <= '0;
      end else if (w_accept && w_last) begin
         r_q <= w_shadow_nxt;
      end
   end

   assign addr = r_addr;
   assign q    = r_q;

endmodule

// File: tb/tb_demux_load_n.sv
// Bench for demux_load_n: an N=8 and an N=5 instance share one input stream
// and are compared every cycle against a frame-level reference model.
module tb_demux_load_n;

   logic       clk;
   logic       rst;
   logic       ls;
   logic       ab;
   logic       dv;
   logic       d;

   logic       rdy8, busy8, fd8;
   logic [2:0] addr8;
   logic [7:0] q8;
   logic       rdy5, busy5, fd5;
   logic [2:0] addr5;
   logic [4:0] q5;

   int n_checks;
   int n_err;

   // Reference model: per instance, a mode (0 idle, 1 loading, 2 done),
   // count of bits collected so far, the collected bits and the committed frame.
   int         m_mode [2];
   int         m_cnt  [2];
   logic [7:0] m_sh   [2];
   logic [7:0] m_q    [2];
   int         NN     [2];

   demux_load_n #(.N(8)) dut8 (
      .clk        (clk),
      .rst        (rst),
      .load_start (ls),
      .abort      (ab),
      .din        (d),
      .din_valid  (dv),
      .din_ready  (rdy8),
      .addr       (addr8),
      .q          (q8),
      .busy       (busy8),
      .frame_done (fd8)
   );

   demux_load_n #(.N(5)) dut5 (
      .clk        (clk),
      .rst        (rst),
      .load_start (ls),
      .abort      (ab),
      .din        (d),
      .din_valid  (dv),
      .din_ready  (rdy5),
      .addr       (addr5),
      .q          (q5),
      .busy       (busy5),
      .frame_done (fd5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_mode[k] = 0;
         m_cnt[k]  = 0;
         m_sh[k]   = '0;
         m_q[k]    = '0;
      end
   endtask

   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         case (m_mode[k])
            0: begin
               if (ls) begin
                  m_mode[k] = 1;
                  m_cnt[k]  = 0;
                  m_sh[k]   = '0;
               end
            end
            1: begin
               if (ab) begin
                  m_mode[k] = 0;
                  m_cnt[k]  = 0;
               end else if (dv) begin
                  m_sh[k][m_cnt[k]] = d;
                  m_cnt[k]++;
                  if (m_cnt[k] == NN[k]) begin
                     m_q[k]    = m_sh[k];
                     m_cnt[k]  = 0;
                     m_mode[k] = 2;
                  end
               end
            end
            default: m_mode[k] = 0;
         endcase
      end
   endtask

   task automatic check_all();
      chk("rdy8",  {31'd0, rdy8},  {31'd0, m_mode[0] == 1});
      chk("busy8", {31'd0, busy8}, {31'd0, m_mode[0] != 0});
      chk("fd8",   {31'd0, fd8},   {31'd0, m_mode[0] == 2});
      chk("addr8", {29'd0, addr8}, m_cnt[0]);
      chk("q8",    {24'd0, q8},    {24'd0, m_q[0]});
      chk("rdy5",  {31'd0, rdy5},  {31'd0, m_mode[1] == 1});
      chk("busy5", {31'd0, busy5}, {31'd0, m_mode[1] != 0});
      chk("fd5",   {31'd0, fd5},   {31'd0, m_mode[1] == 2});
      chk("addr5", {29'd0, addr5}, m_cnt[1]);
      chk("q5",    {27'd0, q5},    {24'd0, m_q[1]});
   endtask

   // One clock: drive inputs, take the edge, then compare 1 time unit later.
   task automatic step(input logic l, input logic a, input logic v, input logic b);
      ls = l;
      ab = a;
      dv = v;
      d  = b;
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic load8(input logic [7:0] val);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, val[i]);
      step(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [7:0] pat;
      logic [4:0] pat5;
      int         cycles;
      int         nfd8;
      int         nfd5;
      logic [2:0] held;

      n_checks = 0;
      n_err    = 0;
      NN[0]    = 8;
      NN[1]    = 5;
      model_reset();
      rst = 1'b1;
      ls  = 1'b0;
      ab  = 1'b0;
      dv  = 1'b0;
      d   = 1'b0;

      // Reset state.
      #7;
      chk("rst_q8",    {24'd0, q8},    32'd0);
      chk("rst_addr8", {29'd0, addr8}, 32'd0);
      chk("rst_busy8", {31'd0, busy8}, 32'd0);
      chk("rst_rdy8",  {31'd0, rdy8},  32'd0);
      chk("rst_fd8",   {31'd0, fd8},   32'd0);
      chk("rst_q5",    {27'd0, q5},    32'd0);
      #1;
      rst = 1'b0;
      #7;

      // Basic load of 1,0,1,1,0,0,1,0 with valid held high.
      pat = 8'h4D;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      cycles = 1;
      chk("start_rdy8", {31'd0, rdy8}, 32'd1);
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b0, 1'b1, pat[i]);
         cycles++;
      end
      chk("basic_q8",  {24'd0, q8},  32'h4D);
      chk("basic_fd8", {31'd0, fd8}, 32'd1);
      for (int i = 0; i < 20 && busy8; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b0);
         cycles++;
      end
      chk("frame_len", cycles, 32'd10);
      chk("fd8_one_cycle", {31'd0, fd8}, 32'd0);

      // Abort after three accepts, abort arriving with a valid bit.
      load8(8'hA5);
      chk("abort_pre_q8", {24'd0, q8}, 32'hA5);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      chk("abort_busy8", {31'd0, busy8}, 32'd0);
      chk("abort_q8",    {24'd0, q8},    32'hA5);
      chk("abort_addr8", {29'd0, addr8}, 32'd0);
      load8(8'h3C);
      chk("after_abort_q8", {24'd0, q8}, 32'h3C);

      // Gapped valid: q holds 3C and addr holds during every gap.
      step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         held = addr8;
         step(1'b0, 1'b0, 1'b0, 1'b0);
         chk("gap_addr8", {29'd0, addr8}, {29'd0, held});
         chk("gap_q8",    {24'd0, q8},    32'h3C);
         step(1'b0, 1'b0, 1'b1, pat[i]);
      end
      chk("gapped_q8", {24'd0, q8}, 32'h4D);
      step(1'b0, 1'b0, 1'b0, 1'b0);

      // N=5 frame 1,1,0,1,1; addr walks 0..4 then wraps.
      pat5 = 5'b11011;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         chk("n5_addr_seq", {29'd0, addr5}, i);
         step(1'b0, 1'b0, 1'b1, pat5[i]);
      end
      chk("n5_q",    {27'd0, q5},    {27'd0, 5'b11011});
      chk("n5_wrap", {29'd0, addr5}, 32'd0);
      step(1'b0, 1'b1, 1'b0, 1'b0);

      // load_start held through LOAD and DONE.
      nfd8 = 0;
      nfd5 = 0;
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
         if (fd8) nfd8++;
         if (fd5) nfd5++;
      end
      chk("held_ls_fd8", nfd8, 32'd2);
      chk("held_ls_fd5", nfd5, 32'd3);
      chk("held_ls_idle8", {31'd0, busy8}, 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 15) == 0),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset between edges after four accepts.
      load8(8'hF7);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_q8",    {24'd0, q8},    32'd0);
      chk("arst_addr8", {29'd0, addr8}, 32'd0);
      chk("arst_busy8", {31'd0, busy8}, 32'd0);
      chk("arst_q5",    {27'd0, q5},    32'd0);
      model_reset();
      check_all();
      #1;
      rst = 1'b0;
      load8(8'h81);
      chk("post_rst_q8", {24'd0, q8}, 32'h81);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
